// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER memory arbiter.
//   state_t : sequencer states (arbitrate, issue, wait latency, respond)
//   grant_t : which requester owns the current access
//   SZ_*    : memory access size encodings
package otter_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/otter_arb2.sv
// Two-way combinational arbiter with last-grant tie-break.
//   IF_REQ, DM_REQ : requests
//   last_grant     : owner of the previous completed access
//   gnt_valid      : any request pending
//   gnt            : winner; DM wins ties unless it won the previous access
module otter_arb2
  import otter_mem_pkg::*;
(
  input  logic   IF_REQ,
  input  logic   DM_REQ,
  input  grant_t last_grant,
  output logic   gnt_valid,
  output grant_t gnt
);

  always_comb begin
    gnt_valid = IF_REQ | DM_REQ;
    gnt       = GNT_IF;
    if (DM_REQ && !(IF_REQ && (last_grant == GNT_DM))) begin
      gnt = GNT_DM;
    end
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data (DM).
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles) -> RESP.
//   CLK, RST                 : clock, async active-low reset
//   IF_REQ/IF_ADDR           : fetch request, held until IF_VALID
//   IF_RDATA/IF_VALID        : fetch data and one-cycle completion pulse
//   DM_REQ/WE/ADDR/WDATA/SIZE: load/store request, held until DM_VALID
//   DM_RDATA/DM_VALID        : load data and one-cycle completion pulse
//   MEM_*                    : single memory port; MEM_RDATA valid MEM_LAT cycles after MEM_EN
//   BUSY                     : sequencer is not idle
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_VALID,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  input  logic [1:0]        DM_SIZE,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              DM_VALID,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [1:0]        MEM_SIZE,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  localparam int unsigned    CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t              state_q, state_d;
  grant_t              last_q, last_d;
  grant_t              gnt_q, gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   if_hold_q, if_hold_d;
  logic [DATA_W-1:0]   dm_hold_q, dm_hold_d;

  logic                arb_valid;
  grant_t              arb_gnt;

  otter_arb2 u_arb (
    .IF_REQ    (IF_REQ),
    .DM_REQ    (DM_REQ),
    .last_grant(last_q),
    .gnt_valid (arb_valid),
    .gnt       (arb_gnt)
  );

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      last_q     <= GNT_IF;
      gnt_q      <= GNT_IF;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      if_hold_q  <= '0;
      dm_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      busy_q     <= busy_d;
      if_hold_q  <= if_hold_d;
      dm_hold_q  <= dm_hold_d;
    end
  end

  // Next-state and next-output logic; strobes are computed one cycle ahead
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    if_hold_d = if_hold_q;
    dm_hold_d = dm_hold_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d  = ST_ISSUE;
          gnt_d    = arb_gnt;
          mem_en_d = 1'b1;
          if (arb_gnt == GNT_DM) begin
            we_d     = DM_WE;
            mem_we_d = DM_WE;
            addr_d   = DM_ADDR;
            wdata_d  = DM_WDATA;
            size_d   = DM_SIZE;
          end else begin
            we_d     = 1'b0;
            addr_d   = IF_ADDR;
            size_d   = SZ_WORD;
          end
        end
      end
      ST_ISSUE: begin
        if (MEM_LAT == 1) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = gnt_q;
        if (gnt_q == GNT_IF) begin
          if_hold_d = MEM_RDATA;
        end else if (!we_q) begin
          dm_hold_d = MEM_RDATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // RESP is only entered from ISSUE/WAIT, where gnt_q already holds the owner
    if_valid_d = (state_d == ST_RESP) && (gnt_q == GNT_IF);
    dm_valid_d = (state_d == ST_RESP) && (gnt_q == GNT_DM);
    busy_d     = (state_d != ST_IDLE);
  end

  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_SIZE  = size_q;
  assign IF_VALID  = if_valid_q;
  assign DM_VALID  = dm_valid_q;
  assign BUSY      = busy_q;

  // Read data bypasses the hold register during the response cycle
  assign IF_RDATA = ((state_q == ST_RESP) && (gnt_q == GNT_IF)) ? MEM_RDATA : if_hold_q;
  assign DM_RDATA = ((state_q == ST_RESP) && (gnt_q == GNT_DM)) ? MEM_RDATA : dm_hold_q;

endmodule
